// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution unit.
// Contents:
//   CC_*  4-bit condition-code encodings. Codes 0-7 match the older 3-bit evaluator.
//   F_*   bit positions of N/V/Z/C inside the 4-bit flag vector {N,V,Z,C}.
package branch_resolve_pkg;

  localparam logic [3:0] CC_NEQ = 4'd0;
  localparam logic [3:0] CC_EQ  = 4'd1;
  localparam logic [3:0] CC_GT  = 4'd2;
  localparam logic [3:0] CC_LT  = 4'd3;
  localparam logic [3:0] CC_GTE = 4'd4;
  localparam logic [3:0] CC_LTE = 4'd5;
  localparam logic [3:0] CC_OV  = 4'd6;
  localparam logic [3:0] CC_UN  = 4'd7;
  localparam logic [3:0] CC_CS  = 4'd8;
  localparam logic [3:0] CC_CC  = 4'd9;
  localparam logic [3:0] CC_HI  = 4'd10;
  localparam logic [3:0] CC_LS  = 4'd11;
  localparam logic [3:0] CC_SGT = 4'd12;
  localparam logic [3:0] CC_SLT = 4'd13;
  localparam logic [3:0] CC_NEV = 4'd14;
  localparam logic [3:0] CC_RSV = 4'd15;

  localparam int unsigned F_N = 3;
  localparam int unsigned F_V = 2;
  localparam int unsigned F_Z = 1;
  localparam int unsigned F_C = 0;

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// Combinational condition evaluator.
// Ports:
//   cc      in  4  condition code
//   flags   in  4  {N,V,Z,C} flags to evaluate against
//   taken   out 1  condition is met
//   illegal out 1  reserved code was used. The branch is then never taken.
module branch_resolve_cond_eval
  import branch_resolve_pkg::*;
(
  input  logic [3:0] cc,
  input  logic [3:0] flags,
  output logic       taken,
  output logic       illegal
);

  logic n, v, z, c;

  assign n = flags[F_N];
  assign v = flags[F_V];
  assign z = flags[F_Z];
  assign c = flags[F_C];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (cc)
      CC_NEQ:  taken = !z;
      CC_EQ:   taken = z;
      CC_GT:   taken = !z && !n;
      CC_LT:   taken = n;
      CC_GTE:  taken = z || !n;
      CC_LTE:  taken = n || z;
      CC_OV:   taken = v;
      CC_UN:   taken = 1'b1;
      CC_CS:   taken = c;
      CC_CC:   taken = !c;
      CC_HI:   taken = c && !z;
      CC_LS:   taken = !c || z;
      CC_SGT:  taken = !z && (n == v);
      CC_SLT:  taken = n != v;
      CC_NEV:  taken = 1'b0;
      CC_RSV:  illegal = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage.
// This stage holds the architectural flag register and evaluates the branch condition.
// It computes the next PC, flags mispredicts and keeps saturating statistics.
// It has one registered result stage, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n                          clock and asynchronous active-low reset
//   flag_we, flag_in, flag_pending      flag register write and the pending-write interlock
//   br_valid/br_ready, br_cc, br_pc,    branch request handshake and payload
//   br_off, br_pred
//   flush                               kills the result stage and any same-cycle accept
//   res_valid/res_ready, res_taken,     result handshake and payload
//   res_next_pc, res_mispred,
//   res_illegal
//   flags                               current flag register
//   cnt_br, cnt_mis                     saturating counters of resolved and mispredicted branches
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned OFF_W  = 9,
  parameter int unsigned PC_INC = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic [3:0]       flag_in,
  input  logic             flag_pending,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [3:0]       br_cc,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [OFF_W-1:0] br_off,
  input  logic             br_pred,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [PC_W-1:0]  res_next_pc,
  output logic             res_mispred,
  output logic             res_illegal,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] cnt_br,
  output logic [CNT_W-1:0] cnt_mis
);

  logic [3:0]       flags_q, flags_d, eff_flags;
  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_mispred_q, res_illegal_q;
  logic [PC_W-1:0]  res_next_pc_q;
  logic [CNT_W-1:0] cnt_br_q, cnt_br_d, cnt_mis_q, cnt_mis_d;
  logic [PC_W-1:0]  fall_pc, target_pc, off_ext;
  logic             accept, consume, cond_taken, cond_illegal;

  // A branch accepted together with a flag write must see the new flags.
  assign eff_flags = flag_we ? flag_in : flags_q;
  assign flags_d   = flag_we ? flag_in : flags_q;

  branch_resolve_cond_eval u_cond_eval (
    .cc      (br_cc),
    .flags   (eff_flags),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  // The cast sign-extends the offset. All PC arithmetic wraps modulo 2^PC_W.
  assign off_ext   = PC_W'($signed(br_off));
  assign fall_pc   = br_pc + PC_W'(PC_INC);
  assign target_pc = fall_pc + off_ext;

  assign br_ready = !flag_pending && !flush && (!res_valid_q || res_ready);
  assign accept   = br_valid && br_ready;
  assign consume  = res_valid_q && res_ready && !flush;

  always_comb begin
    res_valid_d = res_valid_q;
    if (flush) begin
      res_valid_d = 1'b0;
    end else if (accept) begin
      res_valid_d = 1'b1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_br_d  = cnt_br_q;
    cnt_mis_d = cnt_mis_q;
    if (consume) begin
      if (cnt_br_q != '1) begin
        cnt_br_d = cnt_br_q + CNT_W'(1);
      end
      if (res_mispred_q && (cnt_mis_q != '1)) begin
        cnt_mis_d = cnt_mis_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q       <= '0;
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      res_mispred_q <= 1'b0;
      res_illegal_q <= 1'b0;
      res_next_pc_q <= '0;
      cnt_br_q      <= '0;
      cnt_mis_q     <= '0;
    end else begin
      flags_q     <= flags_d;
      res_valid_q <= res_valid_d;
      cnt_br_q    <= cnt_br_d;
      cnt_mis_q   <= cnt_mis_d;
      if (accept) begin
        res_taken_q   <= cond_taken;
        res_mispred_q <= cond_taken != br_pred;
        res_illegal_q <= cond_illegal;
        res_next_pc_q <= cond_taken ? target_pc : fall_pc;
      end
    end
  end

  assign flags       = flags_q;
  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;
  assign res_mispred = res_mispred_q;
  assign res_illegal = res_illegal_q;
  assign res_next_pc = res_next_pc_q;
  assign cnt_br      = cnt_br_q;
  assign cnt_mis     = cnt_mis_q;

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Sequential successor to the combinational branch-condition evaluator: holds the architectural N/V/Z/C flag register, evaluates a 4-bit condition code, computes target/next-PC, detects mispredicts, and keeps saturating statistics counters.
- Sits between decode/execute (branch requests, flag writes) and fetch (redirect).
- Valid/ready handshakes on both request and result sides; one registered result stage.

Parameters:
- PC_W, 16, PC / target width.
- OFF_W, 9, signed branch offset width, sign-extended to PC_W.
- PC_INC, 1, fall-through increment added to br_pc.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flag_we  in  1  write flag register this cycle.
- flag_in  in  4  {N,V,Z,C} new flags.
- flag_pending  in  1  an older flag-setting op is not yet written; blocks acceptance.
- br_valid  in  1  branch request valid.
- br_ready  out  1  request accepted when br_valid & br_ready.
- br_cc  in  4  condition code.
- br_pc  in  PC_W  branch PC.
- br_off  in  OFF_W  signed offset.
- br_pred  in  1  predicted taken.
- flush  in  1  kill result stage and any same-cycle acceptance.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer ready.
- res_taken  out  1  condition met.
- res_next_pc  out  PC_W  resolved next PC.
- res_mispred  out  1  res_taken != br_pred.
- res_illegal  out  1  reserved code used.
- flags  out  4  current flag register.
- cnt_br  out  CNT_W  resolved-branch count.
- cnt_mis  out  CNT_W  mispredict count.

Behaviour:
- Reset (async, rst_n low): flags=0, res_valid=0, res_* data=0, cnt_br=cnt_mis=0. Reset mid-transfer discards everything.
- Flag register: on flag_we, flags <= flag_in at the clock edge.
- Forwarding: a branch accepted in the same cycle as flag_we evaluates against flag_in, not the stale register.
- br_ready = !flag_pending & !flush & (!res_valid | res_ready). It is combinational and does not depend on br_valid.
- Condition codes, evaluated on the effective flags:
  - 0 NEQ: !Z
  - 1 EQ: Z
  - 2 GT: !Z&!N
  - 3 LT: N
  - 4 GTE: Z|!N
  - 5 LTE: N|Z
  - 6 OV: V
  - 7 UN: 1
  - 8 CS: C
  - 9 CC: !C
  - 10 HI: C&!Z
  - 11 LS: !C|Z
  - 12 SGT: !Z&(N==V)
  - 13 SLT: N!=V
  - 14 NEV: 0
  - 15 reserved: taken=0, res_illegal=1
- Codes 0-7 are bit-compatible with the 3-bit predecessor when br_cc[3]=0.
- Arithmetic, modulo 2^PC_W with wrap-around and no overflow flag:
  - fall = br_pc + PC_INC.
  - target = fall + sext(br_off).
  - res_next_pc = taken ? target : fall.
- Latency: accept in cycle t; result visible with res_valid=1 in cycle t+1.
- Result hold: the result is held stable until res_valid & res_ready. Accept and drain in the same cycle is allowed, giving back-to-back throughput of 1/cycle.
- flush: res_valid <= 0 next cycle. The same-cycle request is not accepted (br_ready=0). Counters are not updated for a flushed result.
- Counters:
  - Both update when a result is consumed (res_valid & res_ready & !flush).
  - cnt_br increments; cnt_mis increments if res_mispred.
  - Both saturate at all-ones and never wrap.
- Illegal codes still produce a result and still count.
- flag_pending high: no acceptance. flag_we may still occur; the branch waits until flag_pending deasserts.

Decomposition:
- Shared package: cc encoding localparams (CC_NEQ..CC_RSV, 4-bit) and flag bit-index constants (F_N=3, F_V=2, F_Z=1, F_C=0).
- One natural combinational sub-module: cond_eval (inputs cc[3:0] and flags[3:0]; outputs taken and illegal). It is instantiated once.
- Pipeline register, handshake and counters stay in branch_resolve.

Test Plan:
- Reset, then flag_we with flag_in=4'b0010 (Z). In the next cycle, branch cc=1 with br_pc=16'h0010, br_off=9'h004, pred=0 -> one cycle later res_taken=1, res_next_pc=16'h0015, res_mispred=1; after consumption cnt_mis=1.
- Forwarding: same cycle flag_we with flag_in=4'b0000 and branch cc=1 (flag register holds Z=1) -> res_taken=0, res_next_pc=br_pc+1.
- Sweep all 16 cc × 16 flag values -> taken matches the table. cc=15 gives res_illegal=1, taken=0; codes 0-7 match the 3-bit predecessor.
- Wrap case: br_pc=16'hFFFF, br_off=9'h1FE (−2), cc=7 -> res_next_pc=16'hFFFE. Wrap case: br_pc=16'hFFFF, cc=14 -> res_next_pc=16'h0000.
- Backpressure/flush:
  - Hold res_ready=0 -> br_ready=0 and result stable.
  - Assert flag_pending -> no acceptance.
  - Assert flush with res_valid=1 -> res_valid=0 next cycle, counters unchanged.
- Saturation with CNT_W=2: consume 5 mispredicted branches -> cnt_br=cnt_mis=2'b11.
- Async reset asserted while res_valid=1 -> res_valid=0 immediately, without waiting for a clock edge.
